axil_strobe_wb_bridge: RTL

- Downstream client of the AXI-Lite address merge. Consumes one level-held write or read strobe pair (one `wb_wstr`/`wb_rstr` slot) and runs a single classic Wishbone master cycle per AXI transaction.
- Returns a write or read acknowledge, and read data, in the format the merge ORs into its response path.
- Provides a timeout and error accounting so a hung Wishbone slave never stalls the AXI-Lite bus.

---
 rtl/axil_strobe_wb_bridge_pkg.sv | 18 +
 rtl/axil_strobe_wb_bridge_if.sv | 32 +++
 rtl/axil_strobe_wb_bridge_timeout_ctr.sv | 27 ++
 rtl/axil_strobe_wb_bridge.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/axil_strobe_wb_bridge_pkg.sv
// Shared encodings and constants for the strobe-to-Wishbone bridge and the
// upstream AXI-Lite address merge.
package axil_strobe_wb_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCycle = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } state_e;

  localparam logic [31:0] ErrDataDefault = 32'hBAD0_BAD0;

  // Wishbone slot addresses decoded by the merge
  localparam logic [13:0] WbSlot0Addr = 14'h1;
  localparam logic [13:0] WbSlot1Addr = 14'h2;

endpackage

// File: rtl/axil_strobe_wb_bridge_if.sv
// Strobe-slot side (from the merge) and classic Wishbone master side of the bridge.
interface axil_strobe_wb_bridge_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              wstr;
  logic              rstr;
  logic              wack;
  logic              rack;
  logic [31:0]       dout;

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [31:0]       wb_dat_o;
  logic [31:0]       wb_dat_i;
  logic              wb_ack_i;
  logic              wb_err_i;

  modport master (
    input  addr, wdata, wstr, rstr, wb_dat_i, wb_ack_i, wb_err_i,
    output wack, rack, dout, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output addr, wdata, wstr, rstr, wb_dat_i, wb_ack_i, wb_err_i,
    input  wack, rack, dout, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );

endinterface

// File: rtl/axil_strobe_wb_bridge_timeout_ctr.sv
// 16-bit saturating cycle counter; o_reached flags the last allowed cycle of a
// Wishbone transfer so the bridge aborts after exactly TIMEOUT clocks.
module axil_strobe_wb_bridge_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_reached
);

  localparam logic [15:0] Limit = 16'(TIMEOUT - 1);

  logic [15:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= 16'd0;
    end else if (i_en && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_reached = (r_count >= Limit);

endmodule

// File: rtl/axil_strobe_wb_bridge.sv
// Turns one level-held write/read strobe pair into a single classic Wishbone
// cycle with timeout, error data substitution and sticky/saturating error stats.
module axil_strobe_wb_bridge
  import axil_strobe_wb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ErrDataDefault
) (
  input  logic                    axilClk,
  input  logic                    axilRst,
  axil_strobe_wb_bridge_if.master bus,
  output logic                    err_sticky,
  output logic [15:0]             err_count
);

  state_e            r_state, w_state_d;
  logic              r_wprev, r_rprev;
  logic              r_wpend, r_rpend, w_wpend_d, w_rpend_d;
  logic              r_we, w_we_d;
  logic [ADDR_W-1:0] r_adr, w_adr_d;
  logic [31:0]       r_dat_o, w_dat_d;
  logic              r_cyc, w_cyc_d;
  logic              r_wack, w_wack_d;
  logic              r_rack, w_rack_d;
  logic [31:0]       r_dout, w_dout_d;
  logic              r_drop, w_drop_d;
  logic              r_err_sticky;
  logic [15:0]       r_err_count;
  logic              w_wreq, w_rreq, w_orig, w_fail, w_done, w_reached, w_err_evt;

  // A request survives only while its strobe is still held
  assign w_wreq = (r_wpend | (bus.wstr & ~r_wprev)) & bus.wstr;
  assign w_rreq = (r_rpend | (bus.rstr & ~r_rprev)) & bus.rstr;
  assign w_orig = r_we ? bus.wstr : bus.rstr;
  assign w_fail = bus.wb_err_i | w_reached;
  assign w_done = bus.wb_ack_i | w_fail;

  axil_strobe_wb_bridge_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .i_clk     (axilClk),
    .i_rst     (axilRst),
    .i_clr     (r_state != StCycle),
    .i_en      (r_state == StCycle),
    .o_reached (w_reached)
  );

  always_comb begin
    w_state_d = r_state;
    w_wpend_d = w_wreq;
    w_rpend_d = w_rreq;
    w_we_d    = r_we;
    w_adr_d   = r_adr;
    w_dat_d   = r_dat_o;
    w_cyc_d   = r_cyc;
    w_wack_d  = r_wack;
    w_rack_d  = r_rack;
    w_dout_d  = r_dout;
    w_drop_d  = r_drop;
    w_err_evt = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_wreq || w_rreq) begin
          w_we_d    = w_wreq;
          w_adr_d   = bus.addr;
          w_dat_d   = bus.wdata;
          w_cyc_d   = 1'b1;
          w_drop_d  = 1'b0;
          w_state_d = StCycle;
          if (w_wreq) w_wpend_d = 1'b0;
          else        w_rpend_d = 1'b0;
        end
      end
      StCycle: begin
        if (!w_orig) w_drop_d = 1'b1;
        if (w_done) begin
          w_cyc_d   = 1'b0;
          w_err_evt = w_fail;
          // Upstream abandoned the request: finish quietly, no acknowledge
          if (r_drop || !w_orig) begin
            w_state_d = StIdle;
          end else begin
            w_state_d = StHold;
            w_wack_d  = r_we;
            w_rack_d  = ~r_we;
            if (!r_we) w_dout_d = w_fail ? ERR_DATA : bus.wb_dat_i;
          end
        end
      end
      StHold: begin
        if (!w_orig) begin
          w_wack_d  = 1'b0;
          w_rack_d  = 1'b0;
          w_dout_d  = 32'd0;
          w_state_d = StDrain;
        end
      end
      StDrain: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge axilClk) begin
    if (axilRst) begin
      r_state      <= StIdle;
      r_wprev      <= bus.wstr;
      r_rprev      <= bus.rstr;
      r_wpend      <= 1'b0;
      r_rpend      <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dat_o      <= 32'd0;
      r_cyc        <= 1'b0;
      r_wack       <= 1'b0;
      r_rack       <= 1'b0;
      r_dout       <= 32'd0;
      r_drop       <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_count  <= 16'd0;
    end else begin
      r_state <= w_state_d;
      r_wprev <= bus.wstr;
      r_rprev <= bus.rstr;
      r_wpend <= w_wpend_d;
      r_rpend <= w_rpend_d;
      r_we    <= w_we_d;
      r_adr   <= w_adr_d;
      r_dat_o <= w_dat_d;
      r_cyc   <= w_cyc_d;
      r_wack  <= w_wack_d;
      r_rack  <= w_rack_d;
      r_dout  <= w_dout_d;
      r_drop  <= w_drop_d;
      if (w_err_evt) begin
        r_err_sticky <= 1'b1;
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign bus.wb_cyc_o = r_cyc;
  assign bus.wb_stb_o = r_cyc;
  assign bus.wb_we_o  = r_we;
  assign bus.wb_adr_o = r_adr;
  assign bus.wb_dat_o = r_dat_o;
  assign bus.wack     = r_wack;
  assign bus.rack     = r_rack;
  assign bus.dout     = r_dout;
  assign err_sticky   = r_err_sticky;
  assign err_count    = r_err_count;

endmodule
